matrix_accumulator: RTL
=======================

// Module: matrix_accumulator
// PURPOSE
//  Downstream stage of the 4x4 matrix multiplier. Consumes its 512-bit product
//  matrix (16 x 32-bit elements, element k at [k*IN_W +: IN_W], row-major).
//  Element-wise sums a frame of acc_len product matrices into 16 wide
//  accumulators, then presents the sum matrix on a valid/ready output.
// PARAMETERS
//  DIM    4              matrix dimension; NE = DIM*DIM = 16 elements
//  IN_W   32             product element width, unsigned
//  LEN_W  8              acc_len width; max frame = 2**LEN_W beats
//  ACC_W  IN_W+LEN_W=40  accumulator element width; overflow impossible
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         asynchronous active-low reset
//  clear      in   1         sync flush: abandon frame, return to IDLE
//  acc_len    in   LEN_W     beats per frame (0 => 256); sampled on first beat
//  in_valid   in   1         in_data holds a product matrix
//  in_ready   out  1         accumulator accepts a beat this cycle
//  in_data    in   NE*IN_W   product matrix (512 bits)
//  out_valid  out  1         out_data holds a completed frame sum
//  out_ready  in   1         consumer takes out_data
//  out_data   out  NE*ACC_W  sum matrix (640 bits), element k at [k*ACC_W +: ACC_W]
//  busy       out  1         frame in progress or result held (state != IDLE)
// BEHAVIOUR
//  - Reset (reset=0, any time incl. mid-frame): state=IDLE, all acc=0,
//    beat_cnt=0, len_q=0, out_valid=0, busy=0. in_ready=1 from first cycle after release.
//  - in_ready = (state != HOLD). A beat is accepted when in_valid & in_ready.
//  - States: IDLE -> ACCUM on accepted beat (len != 1); IDLE -> HOLD on accepted beat when len==1;
//    ACCUM -> HOLD on accept with beat_cnt == len-1; HOLD -> IDLE on out_valid & out_ready.
//  - First beat of a frame (IDLE): acc[k] <= zext(in_data[k]); len_q <= (acc_len==0)?256:acc_len;
//    beat_cnt <= 1. Later beats: acc[k] <= acc[k] + zext(in_data[k]), beat_cnt++.
//  - acc_len changes mid-frame are ignored (len_q used).
//  - out_valid=1 exactly in HOLD; rises the cycle after the last beat is accepted (latency 1).
//    out_data = acc registers, stable while out_valid & !out_ready.
//  - Handshake completes in HOLD -> IDLE; in_ready rises same edge; no beat accepted in a
//    cycle where out_valid=1 (one bubble per frame; deliberate, simpler than bypass).
//  - clear=1 (sync): priority over in_valid and out_ready; next state IDLE, out_valid=0,
//    beat_cnt=0; any beat presented that cycle is dropped. acc need not be zeroed (first
//    beat overwrites).
//  - Arithmetic unsigned, zero-extended; ACC_W sized so 256 beats of 2**IN_W-1 cannot wrap.
//  - in_valid with X data while in_ready=0 must not corrupt state.
// STRUCTURE
//  - Package matrix_pkg: DIM, NE, IN_W, LEN_W, ACC_W, state encoding
//    (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2), element slice helper functions.
//  - Sub-module acc_lane (one per element, generated x16): holds acc[k], inputs
//    load_first/add_en/din, output acc. Top holds FSM, beat_cnt, len_q, handshakes.
// TESTING
//  1. acc_len=3, three beats all elements 1,2,3 -> out_valid one cycle after 3rd accept,
//     every element 40'd6; in_ready=0 while held.
//  2. acc_len=4, beat element k = k (k=0..15) -> element k = 4*k; checks lane ordering.
//  3. acc_len=0, 256 beats all 32'hFFFF_FFFF -> every element 40'hFF_FFFF_FF00, no wrap.
//  4. Result held, out_ready=0 for 5 cycles, in_valid pulsing -> out_data/out_valid stable,
//     no beat accepted; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
//  5. acc_len=4, 2 beats of 7, clear=1, then 4 beats of 1 -> element sum 40'd4.
//  6. reset=0 asynchronously mid-frame (between edges) -> out_valid/busy drop immediately,
//     in_ready=1 after release; next frame of acc_len=1 value 9 -> sum 9.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix accumulator: dimensions, widths,
// FSM state encoding and element-slice helpers for the flat matrix buses.
package matrix_pkg;

    localparam int DIM   = 4;
    localparam int NE    = DIM * DIM;
    localparam int IN_W  = 32;
    localparam int LEN_W = 8;
    localparam int ACC_W = IN_W + LEN_W;
    // One extra bit so a frame length of 2**LEN_W is representable.
    localparam int CNT_W = LEN_W + 1;

    localparam logic [CNT_W-1:0] MAX_LEN = {1'b1, {LEN_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Extract product element k from the row-major input matrix.
    function automatic logic [IN_W-1:0] get_in_elem(input logic [NE*IN_W-1:0] data,
                                                    input int k);
        return data[k*IN_W +: IN_W];
    endfunction

    // Zero-extend a product element to accumulator width.
    function automatic logic [ACC_W-1:0] zext_elem(input logic [IN_W-1:0] din);
        return {{(ACC_W-IN_W){1'b0}}, din};
    endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator element. Loads the first beat of a frame, adds later beats.
// Ports:
//   clk, reset (async active-low)
//   load_first  : overwrite acc with zero-extended din
//   add_en      : add zero-extended din to acc
//   din         : product element (IN_W)
//   acc         : accumulated sum (ACC_W), registered
module acc_lane
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_first,
    input  logic             add_en,
    input  logic [IN_W-1:0]  din,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Next accumulator value: load wins over add; otherwise hold.
    always_comb begin
        acc_d = acc_q;
        if (load_first) begin
            acc_d = zext_elem(din);
        end else if (add_en) begin
            acc_d = acc_q + zext_elem(din);
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= {ACC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matrix_accumulator.sv
// Element-wise accumulation of a frame of 4x4 product matrices.
// Ports:
//   clk, reset (async active-low), clear (sync flush)
//   acc_len   : beats per frame, 0 means 256, sampled on the first beat
//   in_valid / in_ready / in_data   : product matrix input (NE*IN_W)
//   out_valid / out_ready / out_data: frame sum output (NE*ACC_W)
//   busy      : frame in progress or result held
module matrix_accumulator
    import matrix_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [LEN_W-1:0]   acc_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NE*IN_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NE*ACC_W-1:0] out_data,
    output logic               busy
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [CNT_W-1:0] beat_cnt_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_d;
    logic [CNT_W-1:0] len_first_s;
    logic             accept_s;
    logic             load_first_s;
    logic             add_en_s;
    logic [ACC_W-1:0] acc_s [NE];

    // Handshake decode; outputs depend only on the state register.
    always_comb begin
        in_ready     = (state_q != HOLD);
        out_valid    = (state_q == HOLD);
        busy         = (state_q != IDLE);
        // A beat presented together with clear is dropped.
        accept_s     = in_valid & in_ready & ~clear;
        load_first_s = accept_s & (state_q == IDLE);
        add_en_s     = accept_s & (state_q == ACCUM);
        if (acc_len == {LEN_W{1'b0}}) begin
            len_first_s = MAX_LEN;
        end else begin
            len_first_s = {1'b0, acc_len};
        end
    end

    // Next-state, beat counter and frame length.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        if (clear) begin
            state_d    = IDLE;
            beat_cnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        len_d      = len_first_s;
                        beat_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                        if (len_first_s == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state_d = HOLD;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (beat_cnt_q == len_q - {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state_d = HOLD;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    beat_cnt_d = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_cnt_q <= {CNT_W{1'b0}};
            len_q      <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
        end
    end

    for (genvar gk = 0; gk < NE; gk++) begin : g_lane
        acc_lane u_lane (
            .clk        (clk),
            .reset      (reset),
            .load_first (load_first_s),
            .add_en     (add_en_s),
            .din        (get_in_elem(in_data, gk)),
            .acc        (acc_s[gk])
        );
        assign out_data[gk*ACC_W +: ACC_W] = acc_s[gk];
    end

endmodule
